fir_tap_multiply: RTL and testbench

//  One FIR tap product: signed 16-bit delay-line sample x signed 16-bit coefficient -> signed 32-bit product.

---
 rtl/fir_pkg.sv | 15 +
 rtl/booth_pp_gen.sv | 33 +++
 rtl/fir_tap_multiply.sv | 76 +++++++
 tb/tb_fir_tap_multiply.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR types and sizes, used by the tap multipliers and by the filter block that sums them.
package fir_pkg;
  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int N_TAPS = 63;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  // Booth digit encodings, named by the multiple of the multiplicand they select
  typedef enum logic [2:0] {
    BD_ZERO = 3'b000, BD_P1A = 3'b001, BD_P1B = 3'b010, BD_P2 = 3'b011,
    BD_M2   = 3'b100, BD_M1A = 3'b101, BD_M1B = 3'b110, BD_ZERO_N = 3'b111
  } booth_win_t;
endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: 3-bit multiplier window selects {-2..+2} x multiplicand.
module booth_pp_gen
  import fir_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int PW    = PROD_W,
  parameter int SHIFT = 0
) (
  input  logic [2:0]    window,
  input  logic [DW-1:0] mcand,
  output logic [PW-1:0] pp,
  output logic          neg
);
  logic [PW-1:0] m1, m2, mag;

  assign m1 = {{(PW-DW){mcand[DW-1]}}, mcand};
  assign m2 = m1 << 1;

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (booth_win_t'(window))
      BD_P1A, BD_P1B: mag = m1;
      BD_P2:          mag = m2;
      BD_M2:          begin mag = m2; neg = 1'b1; end
      BD_M1A, BD_M1B: begin mag = m1; neg = 1'b1; end
      default:        begin mag = '0; neg = 1'b0; end
    endcase
  end

  // Negative digits emit ~mag; the +1 is injected separately at bit SHIFT by the caller.
  assign pp = (neg ? ~mag : mag) << SHIFT;
endmodule

// File: rtl/fir_tap_multiply.sv
// FIR tap product: two-stage pipelined signed DWxDW multiply (Booth radix-4 + CSA tree) with stall.
module fir_tap_multiply
  import fir_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int PW = PROD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [DW-1:0] delay_x,
  input  logic [DW-1:0] coef,
  output logic [PW-1:0] acc,
  output logic          acc_vld
);
  localparam int ND = DW / 2;

  logic [DW-1:0]          x_q, c_q;
  logic [DW:0]            bx;
  logic [ND-1:0][PW-1:0]  pp;
  logic [ND-1:0]          neg;
  logic [PW-1:0]          inj, prod;
  logic [1:0]             vld_cnt;

  function automatic logic [2*PW-1:0] csa3(input logic [PW-1:0] a, b, c);
    logic [PW-1:0] s, maj;
    s   = a ^ b ^ c;
    maj = (a & b) | (a & c) | (b & c);
    return {s, maj << 1};
  endfunction

  assign bx = {c_q, 1'b0};

  for (genvar i = 0; i < ND; i++) begin : g_pp
    booth_pp_gen #(.DW(DW), .PW(PW), .SHIFT(2*i)) u_pp (
      .window (bx[2*i+2 -: 3]),
      .mcand  (x_q),
      .pp     (pp[i]),
      .neg    (neg[i])
    );
  end

  always_comb begin
    inj = '0;
    for (int i = 0; i < ND; i++) inj[2*i] = neg[i];
  end

  // Nine rows (8 partial products + negate injections) reduced 9->6->4->3->2
  logic [PW-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
  always_comb begin
    {s0, c0} = csa3(pp[0], pp[1], pp[2]);
    {s1, c1} = csa3(pp[3], pp[4], pp[5]);
    {s2, c2} = csa3(pp[6], pp[7], inj);
    {s3, c3} = csa3(s0, c0, s1);
    {s4, c4} = csa3(c1, s2, c2);
    {s5, c5} = csa3(s3, c3, s4);
    {s6, c6} = csa3(s5, c5, c4);
    prod     = s6 + c6;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      c_q     <= '0;
      acc     <= '0;
      vld_cnt <= '0;
    end else if (ena) begin
      x_q <= delay_x;
      c_q <= coef;
      acc <= prod;
      if (vld_cnt != 2'd2) vld_cnt <= vld_cnt + 2'd1;
    end
  end

  assign acc_vld = vld_cnt[1];
endmodule

// File: tb/tb_fir_tap_multiply.sv
// Directed/table bench for fir_tap_multiply: latency, stall, reset and arithmetic corners.
module tb_fir_tap_multiply;
  logic        clk = 1'b0;
  logic        rst, ena;
  logic [15:0] delay_x, coef;
  logic [31:0] acc;
  logic        acc_vld;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] c;
    logic [31:0] p;
  } vec_t;
  vec_t vecs[$];

  fir_tap_multiply dut (
    .clk(clk), .rst(rst), .ena(ena), .delay_x(delay_x), .coef(coef),
    .acc(acc), .acc_vld(acc_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] c);
    int xi, ci;
    xi = int'($signed(x));
    ci = int'($signed(c));
    return 32'(xi * ci);
  endfunction

  task automatic run_stream();
    for (int k = 0; k <= vecs.size(); k++) begin
      if (k < vecs.size()) begin
        delay_x = vecs[k].x;
        coef    = vecs[k].c;
      end
      tick();
      if (k >= 1) chk($sformatf("vec%0d %h*%h", k-1, vecs[k-1].x, vecs[k-1].c), acc, vecs[k-1].p);
    end
  endtask

  logic [15:0] corners[5];
  logic [15:0] rx, rc;

  initial begin
    corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'hFFFF;
    corners[3] = 16'h8000; corners[4] = 16'h7FFF;

    // Hand-computed products
    vecs.push_back('{16'h8000, 16'd125,  32'hFFC18000});
    vecs.push_back('{16'h8000, 16'h8000, 32'h40000000});
    vecs.push_back('{16'h7FFF, 16'h7FFF, 32'h3FFF0001});
    vecs.push_back('{16'h7FFF, 16'h8000, 32'hC0008000});
    vecs.push_back('{16'hFFFF, 16'h8000, 32'h00008000});
    vecs.push_back('{16'd7,    16'd9,    32'd63});
    vecs.push_back('{16'd0,    16'hFFFB, 32'd0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 32'd1});
    vecs.push_back('{16'd1234, 16'hFFFE, 32'hFFFFF65C});
    vecs.push_back('{16'hFED4, 16'd300,  32'hFFFEA070});
    vecs.push_back('{16'd12345, 16'd2,   32'h00006072});

    rst = 1'b1; ena = 1'b0; delay_x = '0; coef = '0;
    #3;
    chk("reset acc", acc, 32'd0);
    chk("reset vld", {31'd0, acc_vld}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Test 1: first product and valid timing
    ena = 1'b1; delay_x = 16'd100; coef = 16'hFFFF;
    tick();
    chk("t1 vld after 1 edge", {31'd0, acc_vld}, 32'd0);
    tick();
    chk("t1 acc", acc, 32'hFFFFFF9C);
    chk("t1 vld", {31'd0, acc_vld}, 32'd1);

    // Tests 2/3: back-to-back table stream
    run_stream();

    // Test 6: corner cross-product plus random pairs against the model
    vecs.delete();
    foreach (corners[i]) foreach (corners[j])
      vecs.push_back('{corners[i], corners[j], model(corners[i], corners[j])});
    for (int k = 0; k < 2000; k++) begin
      rx = 16'($urandom);
      rc = 16'($urandom);
      vecs.push_back('{rx, rc, model(rx, rc)});
    end
    run_stream();

    // Test 4: stall holds everything, no bubbles
    delay_x = 16'd11; coef = 16'hFFFD; tick();
    delay_x = 16'd7;  coef = 16'd9;    tick();
    chk("t4 pre-stall acc", acc, 32'hFFFFFFDF);
    ena = 1'b0; delay_x = 16'd5; coef = 16'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t4 stall%0d acc", k), acc, 32'hFFFFFFDF);
      chk($sformatf("t4 stall%0d vld", k), {31'd0, acc_vld}, 32'd1);
    end
    ena = 1'b1; delay_x = 16'd2; coef = 16'd3;
    tick();
    chk("t4 resume acc", acc, 32'd63);
    tick();
    chk("t4 next acc", acc, 32'd6);

    // Test 5: async reset between edges discards in-flight data
    delay_x = 16'd9; coef = 16'd9;
    #2;
    rst = 1'b1;
    #1;
    chk("t5 async acc", acc, 32'd0);
    chk("t5 async vld", {31'd0, acc_vld}, 32'd0);
    tick();
    rst = 1'b0; delay_x = 16'd4; coef = 16'hFFFC;
    tick();
    chk("t5 edge1 acc", acc, 32'd0);
    chk("t5 edge1 vld", {31'd0, acc_vld}, 32'd0);
    tick();
    chk("t5 edge2 acc", acc, 32'hFFFFFFF0);
    chk("t5 edge2 vld", {31'd0, acc_vld}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
